// File: rtl/time_measurement_mc.sv
// Multi-channel enable-duration timer.
// Each channel counts how many clock edges its en input is sampled high, in
// units of PRESCALE cycles. On the first low sample it latches the count into
// res and pulses valid for one cycle. Counter overflow either saturates or
// wraps, depending on SAT_MODE, and is reported on ovf.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   en     - per-channel measurement enable (CHANNELS bits)
//   clr    - synchronous clear of all channels
//   res    - latched results, channel i at [i*WIDTH +: WIDTH]
//   valid  - one-cycle pulse per channel when a new result is latched
//   ovf    - overflow flag belonging to the current res of each channel
//   busy   - high while the channel is measuring
module time_measurement_mc #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 6,
  parameter int unsigned PRESCALE = 10,
  parameter bit          SAT_MODE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      clr,
  output logic [CHANNELS*WIDTH-1:0] res,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       busy
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_RUN    = 1'b1;
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  // Registered en for edge detection; resets high so a held-high en does not
  // start a measurement at reset release.
  logic [CHANNELS-1:0] r_en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_en_d <= '1;
    else        r_en_d <= en;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [0:0]       r_state, w_state_nx;
    logic [PW-1:0]    r_pre, w_pre_nx, w_pre_base, w_pre_adv;
    logic [WIDTH-1:0] r_cnt, w_cnt_nx, w_cnt_base, w_cnt_adv;
    logic             r_lovf, w_lovf_nx, w_lovf_base, w_lovf_adv;
    logic [WIDTH-1:0] r_res, w_res_nx;
    logic             r_ovf, w_ovf_nx;
    logic             r_valid, w_valid_nx;
    logic             r_busy, w_busy_nx;

    // One high cycle applied to the live count; a start begins from zero so
    // the prescaler phase aligns with the start edge.
    always_comb begin
      w_pre_base  = (r_state == S_RUN) ? r_pre  : '0;
      w_cnt_base  = (r_state == S_RUN) ? r_cnt  : '0;
      w_lovf_base = (r_state == S_RUN) ? r_lovf : 1'b0;
      w_pre_adv   = w_pre_base + PW'(1);
      w_cnt_adv   = w_cnt_base;
      w_lovf_adv  = w_lovf_base;
      if (w_pre_base == PRE_LAST) begin
        w_pre_adv = '0;
        if (w_cnt_base == CNT_MAX) begin
          w_lovf_adv = 1'b1;
          w_cnt_adv  = SAT_MODE ? CNT_MAX : '0;
        end else begin
          w_cnt_adv = w_cnt_base + WIDTH'(1);
        end
      end
    end

    // Next-state and output logic
    always_comb begin
      w_state_nx = r_state;
      w_pre_nx   = r_pre;
      w_cnt_nx   = r_cnt;
      w_lovf_nx  = r_lovf;
      w_res_nx   = r_res;
      w_ovf_nx   = r_ovf;
      w_valid_nx = 1'b0;
      w_busy_nx  = r_busy;
      if (clr) begin
        w_state_nx = S_IDLE;
        w_pre_nx   = '0;
        w_cnt_nx   = '0;
        w_lovf_nx  = 1'b0;
        w_res_nx   = '0;
        w_ovf_nx   = 1'b0;
        w_busy_nx  = 1'b0;
      end else if (r_state == S_IDLE) begin
        if (en[g] && !r_en_d[g]) begin
          w_state_nx = S_RUN;
          w_pre_nx   = w_pre_adv;
          w_cnt_nx   = w_cnt_adv;
          w_lovf_nx  = w_lovf_adv;
          w_busy_nx  = 1'b1;
        end
      end else begin
        if (en[g]) begin
          w_pre_nx  = w_pre_adv;
          w_cnt_nx  = w_cnt_adv;
          w_lovf_nx = w_lovf_adv;
        end else begin
          w_state_nx = S_IDLE;
          w_res_nx   = r_cnt;
          w_ovf_nx   = r_lovf;
          w_valid_nx = 1'b1;
          w_busy_nx  = 1'b0;
        end
      end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_pre   <= '0;
        r_cnt   <= '0;
        r_lovf  <= 1'b0;
        r_res   <= '0;
        r_ovf   <= 1'b0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_pre   <= w_pre_nx;
        r_cnt   <= w_cnt_nx;
        r_lovf  <= w_lovf_nx;
        r_res   <= w_res_nx;
        r_ovf   <= w_ovf_nx;
        r_valid <= w_valid_nx;
        r_busy  <= w_busy_nx;
      end
    end

    assign res[g*WIDTH +: WIDTH] = r_res;
    assign ovf[g]                = r_ovf;
    assign valid[g]              = r_valid;
    assign busy[g]               = r_busy;
  end

endmodule

// File: doc/time_measurement_mc.md
Name: time_measurement_mc

Overview:
- Multi-channel, parametrised successor to the single-channel enable-duration timer used by the train controller.
- Each channel measures how long its `en` input stays high, in units of PRESCALE clock cycles.
- On the falling edge of `en`, each channel latches the result and pulses `valid`. Overflow is flagged, with selectable saturate or wrap handling.
- Sits between the track-sensor/enable logic and the speed/control FSM, which consumes `res` when `valid` pulses.

Parameters:
- CHANNELS, 2, number of independent measurement channels (≥1).
- WIDTH, 6, result width per channel in bits (≥2).
- PRESCALE, 10, clock cycles per result LSB (≥1).
- SAT_MODE, 1, 1 = saturate at all-ones on overflow; 0 = wrap modulo 2^WIDTH.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  CHANNELS  per-channel measurement enable; synchronous to clk.
- clr  input  1  synchronous clear of all channels.
- res  output  CHANNELS*WIDTH  latched results; channel i occupies bits [i*WIDTH +: WIDTH].
- valid  output  CHANNELS  one-cycle pulse per channel when a new result is latched.
- ovf  output  CHANNELS  overflow flag belonging to the current res of that channel.
- busy  output  CHANNELS  high while the channel is in RUN.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - res=0, valid=0, ovf=0, busy=0.
  - All channels go to IDLE; prescaler and live counter are 0.
  - The registered copy of en (en_d) resets to all-ones. A channel whose en is high at reset release does not start; it must first see en=0.
- Per channel, 2-state FSM:
  - IDLE:
    - Rising edge detected (en=1, en_d=0 at a clk edge) → RUN.
    - That edge counts as the first high cycle.
  - RUN:
    - Every clk edge with en=1 advances the prescaler.
    - Every PRESCALE high cycles, the live counter increments.
    - The first edge with en=0 → IDLE. At that edge:
      - res[i] ← live count
      - ovf[i] ← live overflow
      - valid[i] = 1 for exactly the next cycle
      - busy[i] falls
- Result rule: with H = number of consecutive clk edges at which en[i] was sampled 1, res = floor(H / PRESCALE).
  - Subject to overflow handling below.
  - A 1-cycle en pulse gives H=1.
- Overflow: when an increment is due and the live count equals 2^WIDTH−1:
  - SAT_MODE=1: hold at 2^WIDTH−1.
  - SAT_MODE=0: wrap to 0.
  - In both modes, set the live overflow bit. It is cleared only at the next start.
- Latency and outputs:
  - busy rises one cycle after the rising edge of en is sampled.
  - valid rises one cycle after the falling edge of en is sampled.
  - res and ovf update in the same cycle valid rises, and hold until the next result, clr or reset.
- Restart: en may re-rise on the edge right after a stop edge. The new measurement starts normally; the prior result and valid pulse are unaffected.
- Start resets the prescaler and live counter, so the prescaler phase is aligned to the start edge. The prescaler is not free-running.
- clr=1 at a clk edge:
  - All channels → IDLE; res=0, ovf=0, valid=0.
  - Prescalers and counters are zeroed.
  - en_d still tracks en, so a channel held high does not restart until it toggles.
  - clr takes priority over a simultaneous start or stop; no valid pulse is produced.
- Channels are fully independent. Simultaneous stops on several channels give simultaneous valid pulses.

Test Plan:
- Defaults, clk period 10 ns, en[0] high 200 ns (H=20) → busy[0] high for 20 cycles; res[0]=2, ovf[0]=0; valid[0] high exactly 1 cycle after the falling edge is sampled.
- en[0] high H=19 and en[1] high H=35, overlapping → res[0]=1, res[1]=3; valids pulse independently at their respective stop edges.
- Overflow at H=640 (WIDTH=6, PRESCALE=10):
  - SAT_MODE=1 → res=63, ovf=1.
  - SAT_MODE=0 → res=0, ovf=1.
  - H=639 → res=63, ovf=0.
  - A following run with H=20 → res=2, ovf=0.
- Short pulses: H=1 → res=0 with a valid pulse. With PRESCALE=1, H=1 → res=1. Back-to-back runs (H=20, 1 low cycle, H=30) → results 2 then 3.
- Asynchronous reset: rst_n asserted mid-run (H=15 so far) → all outputs 0 immediately. With en still high at release → no start and no valid until en goes low and re-rises.
- clr asserted on the same edge as a stop of a run with H=25 → no valid pulse; res=0, ovf=0, busy=0.
